// File: rtl/lsu_mem_initiator.sv
// Load/store initiator for a byte-addressed data memory: issues aligned accesses
// directly, splits misaligned halfword/word accesses into byte accesses, and extends loads.
module lsu_mem_initiator #(
    parameter int MEM_BYTES = 64,
    parameter int ADDR_W    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_load,
    input  logic              req_store,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [1:0]        mem_sel,
    output logic              mem_signed,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_fault,
    output logic              busy
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_SPLIT  = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;

    logic [1:0]        r_state;
    logic              r_load;
    logic              r_store;
    logic [1:0]        r_size;
    logic              r_signed;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [1:0]        r_idx;
    logic [31:0]       r_result;
    logic              r_fault;

    logic [2:0]        w_nbytes;
    logic [32:0]       w_last_byte;
    logic              w_range_fault;
    logic              w_fault;
    logic              w_aligned;
    logic              w_accept;
    logic [1:0]        w_last_idx;
    logic [4:0]        w_bit_ofs;
    logic [31:0]       w_ext;

    // Request decode, evaluated on the incoming request while IDLE.
    always_comb begin
        case (req_size)
            SZ_WORD: w_nbytes = 3'd4;
            SZ_HALF: w_nbytes = 3'd2;
            default: w_nbytes = 3'd1;
        endcase
    end

    // 33-bit sum so an address near 2^32 cannot wrap back into range.
    assign w_last_byte   = {1'b0, req_addr} + {30'b0, w_nbytes} - 33'd1;
    assign w_range_fault = (w_last_byte >= 33'(MEM_BYTES));
    assign w_fault       = (req_load == req_store) || (req_size == 2'b11) || w_range_fault;

    always_comb begin
        case (req_size)
            SZ_WORD: w_aligned = (req_addr[1:0] == 2'b00);
            SZ_HALF: w_aligned = ~req_addr[0];
            default: w_aligned = 1'b1;
        endcase
    end

    assign w_accept = req_valid && (r_state == S_IDLE);

    always_comb begin
        case (r_size)
            SZ_WORD: w_last_idx = 2'd3;
            SZ_HALF: w_last_idx = 2'd1;
            default: w_last_idx = 2'd0;
        endcase
    end

    assign w_bit_ofs = {r_idx, 3'b000};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_load   <= 1'b0;
            r_store  <= 1'b0;
            r_size   <= 2'b00;
            r_signed <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_idx    <= 2'd0;
            r_result <= '0;
            r_fault  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_load   <= req_load;
                        r_store  <= req_store;
                        r_size   <= req_size;
                        r_signed <= req_signed;
                        r_addr   <= req_addr[ADDR_W-1:0];
                        r_wdata  <= req_wdata;
                        r_idx    <= 2'd0;
                        r_result <= '0;
                        r_fault  <= w_fault;
                        if (w_fault) begin
                            r_state <= S_DONE;
                        end else if (w_aligned) begin
                            r_state <= S_ACCESS;
                        end else begin
                            r_state <= S_SPLIT;
                        end
                    end
                end
                S_ACCESS: begin
                    if (r_load) begin
                        r_result <= mem_rdata;
                    end
                    r_state <= S_DONE;
                end
                S_SPLIT: begin
                    if (r_load) begin
                        r_result[w_bit_ofs +: 8] <= mem_rdata[7:0];
                    end
                    if (r_idx == w_last_idx) begin
                        r_state <= S_DONE;
                    end else begin
                        r_idx <= r_idx + 2'd1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Memory strobes are pure decode of state so an asynchronous reset drops them at once.
    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_sel   = 2'b00;
        mem_addr  = '0;
        mem_wdata = '0;
        case (r_state)
            S_ACCESS: begin
                mem_read  = r_load;
                mem_write = r_store && !r_load;
                mem_sel   = r_size;
                mem_addr  = r_addr;
                mem_wdata = r_wdata;
            end
            S_SPLIT: begin
                mem_read  = r_load;
                mem_write = r_store && !r_load;
                mem_sel   = SZ_BYTE;
                mem_addr  = r_addr + ADDR_W'(r_idx);
                mem_wdata = {24'b0, r_wdata[w_bit_ofs +: 8]};
            end
            default: begin
                mem_read  = 1'b0;
                mem_write = 1'b0;
            end
        endcase
    end

    assign mem_signed = 1'b0;

    always_comb begin
        case (r_size)
            SZ_BYTE: w_ext = {{24{r_signed & r_result[7]}}, r_result[7:0]};
            SZ_HALF: w_ext = {{16{r_signed & r_result[15]}}, r_result[15:0]};
            default: w_ext = r_result;
        endcase
    end

    assign resp_valid = (r_state == S_DONE);
    assign resp_fault = resp_valid && r_fault;
    assign resp_rdata = (resp_valid && r_load && !r_fault) ? w_ext : 32'd0;
    assign req_ready  = (r_state == S_IDLE);
    assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Bench for lsu_mem_initiator: directed cases plus randomized loads/stores checked
// against a transaction-level model of memory contents, latency and strobe sequence.
module tb_lsu_mem_initiator;

    localparam int MEM_BYTES = 64;
    localparam int ADDR_W    = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic              req_load;
    logic              req_store;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic              mem_read;
    logic              mem_write;
    logic [1:0]        mem_sel;
    logic              mem_signed;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_fault;
    logic              busy;

    logic [7:0] tb_mem  [0:MEM_BYTES-1];
    logic [7:0] ref_mem [0:MEM_BYTES-1];

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] last_rdata;

    lsu_mem_initiator #(.MEM_BYTES(MEM_BYTES), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_load   (req_load),
        .req_store  (req_store),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_sel    (mem_sel),
        .mem_signed (mem_signed),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_fault (resp_fault),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Byte memory: little-endian, combinational read, write on rising edge.
    always_comb begin
        int nbm;
        nbm = 1;
        mem_rdata = '0;
        if (mem_read) begin
            nbm = (mem_sel == 2'b00) ? 4 : (mem_sel == 2'b01) ? 2 : 1;
            for (int i = 0; i < 4; i++) begin
                if (i < nbm && int'(mem_addr) + i < MEM_BYTES) begin
                    mem_rdata[8*i +: 8] = tb_mem[int'(mem_addr) + i];
                end
            end
        end
    end

    always @(posedge clk) begin
        if (mem_write) begin
            for (int i = 0; i < 4; i++) begin
                if (i < ((mem_sel == 2'b00) ? 4 : (mem_sel == 2'b01) ? 2 : 1) &&
                    int'(mem_addr) + i < MEM_BYTES) begin
                    tb_mem[int'(mem_addr) + i] = mem_wdata[8*i +: 8];
                end
            end
        end
    end

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_ready();
        for (int w = 0; w < 20 && !req_ready; w++) @(negedge clk);
        check_value("ready wait", {31'b0, req_ready}, 32'd1);
    endtask

    // One complete transaction; expectations come from ref_mem and the access rules.
    task automatic do_req(input logic ld, input logic st, input logic [1:0] sz,
                          input logic sg, input logic [31:0] ad, input logic [31:0] wd);
        int          nb;
        bit          flt;
        bit          aligned;
        int          exp_lat;
        int          exp_strb;
        int          lat;
        int          strb;
        logic [31:0] raw;
        logic [31:0] exp_rd;
        logic [31:0] exp_a;

        nb      = (sz == 2'b00) ? 4 : (sz == 2'b01) ? 2 : 1;
        flt     = (ld == st) || (sz == 2'b11) || (64'(ad) + 64'(nb) - 1 >= 64'(MEM_BYTES));
        aligned = (sz == 2'b10) || (sz == 2'b01 && ad % 2 == 0) || (sz == 2'b00 && ad % 4 == 0);
        exp_lat  = flt ? 1 : aligned ? 2 : nb + 1;
        exp_strb = flt ? 0 : aligned ? 1 : nb;

        raw = 0;
        if (!flt && ld) begin
            for (int i = 0; i < nb; i++) raw = raw + (32'(ref_mem[int'(ad) + i]) << (8 * i));
        end
        exp_rd = raw;
        if (flt || !ld) exp_rd = 0;
        else if (sz == 2'b10 && sg && raw >= 128) exp_rd = raw - 32'd256;
        else if (sz == 2'b01 && sg && raw >= 32768) exp_rd = raw - 32'd65536;
        if (!flt && st) begin
            for (int i = 0; i < nb; i++) ref_mem[int'(ad) + i] = wd[8*i +: 8];
        end

        wait_ready();
        req_valid = 1'b1; req_load = ld; req_store = st; req_size = sz;
        req_signed = sg; req_addr = ad; req_wdata = wd;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;

        lat  = 0;
        strb = 0;
        for (int c = 1; c <= 20 && lat == 0; c++) begin
            if (mem_read || mem_write) begin
                exp_a = aligned ? ad : ad + 32'(strb);
                check_value("excl", {31'b0, mem_read & mem_write}, 32'd0);
                check_value("dir", {30'b0, mem_read, mem_write}, {30'b0, ld, st});
                check_value("addr", {24'b0, mem_addr}, {24'b0, exp_a[7:0]});
                check_value("sel", {30'b0, mem_sel}, aligned ? {30'b0, sz} : 32'd2);
                if (st) check_value("wdata", mem_wdata, aligned ? wd : {24'b0, wd[8*strb +: 8]});
                strb++;
            end
            if (resp_valid) begin
                lat = c;
                last_rdata = resp_rdata;
                check_value("rdata", resp_rdata, exp_rd);
                check_value("fault", {31'b0, resp_fault}, {31'b0, flt});
            end else begin
                @(negedge clk);
            end
        end
        check_value("latency", lat, exp_lat);
        check_value("strobes", strb, exp_strb);
        $display("txn ld=%0d st=%0d sz=%0d sg=%0d addr=%h wd=%h lat=%0d rdata=%h flt=%0d",
                 ld, st, sz, sg, ad, wd, lat, last_rdata, flt);
    endtask

    initial begin
        int          first_resp;
        int          second_resp;
        int          n_resp;
        int          b_acc;
        logic [31:0] wa;
        logic [31:0] b_data;
        logic        ld;
        logic        st;
        logic [1:0]  sz;
        logic [31:0] ad;
        int          v;

        for (int i = 0; i < MEM_BYTES; i++) begin
            tb_mem[i]  = 8'h00;
            ref_mem[i] = 8'h00;
        end
        tb_mem[4]  = 8'h09;
        ref_mem[4] = 8'h09;

        rst_n = 1'b0; req_valid = 1'b0; req_load = 1'b0; req_store = 1'b0;
        req_size = 2'b00; req_signed = 1'b0; req_addr = '0; req_wdata = '0;
        repeat (2) @(negedge clk);
        check_value("rst ready", {31'b0, req_ready}, 32'd1);
        check_value("rst busy", {31'b0, busy}, 32'd0);
        check_value("rst strobes", {30'b0, mem_read, mem_write}, 32'd0);
        check_value("rst resp", {30'b0, resp_valid, resp_fault}, 32'd0);
        check_value("rst rdata", resp_rdata, 32'd0);
        check_value("rst memsig", {31'b0, mem_signed}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases
        do_req(1, 0, 2'b00, 0, 32'h4, 32'h0);
        check_value("lw4 const", last_rdata, 32'h0000_0009);
        do_req(0, 1, 2'b00, 0, 32'h5, 32'hDEAD_BEEF);
        do_req(1, 0, 2'b00, 0, 32'h5, 32'h0);
        check_value("lw5 const", last_rdata, 32'hDEAD_BEEF);
        do_req(0, 1, 2'b10, 0, 32'h10, 32'h0000_0080);
        do_req(1, 0, 2'b10, 1, 32'h10, 32'h0);
        check_value("lb const", last_rdata, 32'hFFFF_FF80);
        do_req(1, 0, 2'b10, 0, 32'h10, 32'h0);
        check_value("lbu const", last_rdata, 32'h0000_0080);
        do_req(0, 1, 2'b10, 0, 32'h4, 32'h0000_0080);
        do_req(1, 0, 2'b01, 1, 32'h3, 32'h0);
        check_value("lh const", last_rdata, 32'hFFFF_8000);
        do_req(1, 0, 2'b00, 0, 32'h3E, 32'h0);
        do_req(1, 0, 2'b11, 0, 32'h8, 32'h0);
        do_req(1, 1, 2'b10, 0, 32'h8, 32'h55);
        do_req(0, 1, 2'b01, 0, 32'hFFFF_FFFF, 32'h1234);

        // Reset during byte 2 of a split store: only bytes 9 and 10 land.
        wait_ready();
        req_valid = 1'b1; req_load = 1'b0; req_store = 1'b1; req_size = 2'b00;
        req_signed = 1'b0; req_addr = 32'h9; req_wdata = 32'h1122_3344;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        check_value("split idx2 write", {31'b0, mem_write}, 32'd1);
        check_value("split idx2 addr", {24'b0, mem_addr}, 32'd11);
        rst_n = 1'b0;
        #1;
        check_value("rst drop write", {31'b0, mem_write}, 32'd0);
        ref_mem[9]  = 8'h44;
        ref_mem[10] = 8'h33;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_value("post rst ready", {31'b0, req_ready}, 32'd1);
        check_value("post rst busy", {31'b0, busy}, 32'd0);
        $display("txn reset-abort store addr=00000009");

        // Second request held on req_valid while a split store is in flight.
        wa = $urandom;
        wait_ready();
        req_valid = 1'b1; req_load = 1'b0; req_store = 1'b1; req_size = 2'b00;
        req_signed = 1'b0; req_addr = 32'h21; req_wdata = wa;
        for (int i = 0; i < 4; i++) ref_mem[33 + i] = wa[8*i +: 8];
        @(posedge clk);
        @(negedge clk);
        req_load = 1'b1; req_store = 1'b0; req_size = 2'b10; req_addr = 32'h21;
        first_resp = 0; second_resp = 0; n_resp = 0; b_acc = 0; b_data = '0;
        for (int c = 1; c <= 12; c++) begin
            if (resp_valid) begin
                n_resp++;
                if (first_resp == 0) first_resp = c;
                else begin
                    second_resp = c;
                    b_data = resp_rdata;
                end
            end
            if (req_ready && req_valid && b_acc == 0) b_acc = c;
            @(negedge clk);
            if (b_acc != 0) req_valid = 1'b0;
        end
        req_valid = 1'b0;
        check_value("held first resp", first_resp, 5);
        check_value("held accept", b_acc, 6);
        check_value("held second resp", second_resp, 8);
        check_value("held resp count", n_resp, 2);
        check_value("held b data", b_data, {24'b0, wa[7:0]});
        $display("txn held pair sw@21 wd=%h then lbu@21 rdata=%h", wa, b_data);

        // Randomized traffic
        for (int t = 0; t < 150; t++) begin
            v = $urandom_range(0, 15);
            if (v == 0) begin
                ld = 1'($urandom_range(0, 1));
                st = ld;
            end else begin
                ld = 1'($urandom_range(0, 1));
                st = !ld;
            end
            v  = $urandom_range(0, 7);
            sz = (v == 7) ? 2'b11 : 2'(v % 3);
            if ($urandom_range(0, 19) == 0) ad = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            else ad = 32'($urandom_range(0, 66));
            do_req(ld, st, sz, 1'($urandom_range(0, 1)), ad, $urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        for (int i = 0; i < MEM_BYTES; i++) begin
            check_value($sformatf("mem[%0d]", i), {24'b0, tb_mem[i]}, {24'b0, ref_mem[i]});
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/lsu_mem_initiator.md
Name: lsu_mem_initiator

Overview:
- Load/store unit on the processor side of the byte-addressed data memory port; it is the initiator for that memory.
- Accepts one load or store from the execute stage and drives the memory strobes, size select, address and write data.
- Splits misaligned halfword and word accesses into sequential byte accesses.
- Performs all sign and zero extension itself, returns the load result, and raises busy to stall the pipeline.

Parameters:
- MEM_BYTES, 64, number of addressable bytes; an access touching a byte at or above this address is a fault.
- ADDR_W, 8, width of mem_addr.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present this cycle.
- req_ready  out  1  high only in IDLE; a request is accepted when req_valid && req_ready.
- req_load  in  1  request is a load.
- req_store  in  1  request is a store.
- req_size  in  2  00 word, 01 halfword, 10 byte, 11 illegal.
- req_signed  in  1  1 = sign-extend the load result, 0 = zero-extend.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; the low bytes are used for halfword and byte stores.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe, sampled by the memory on the rising edge.
- mem_sel  out  2  memory access size, same encoding as req_size.
- mem_signed  out  1  tied to 0; the memory is always asked for unsigned data.
- mem_addr  out  ADDR_W  memory byte address.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data; combinational from address and strobes.
- resp_valid  out  1  one-cycle pulse when the access completes.
- resp_rdata  out  32  extended load data; 0 for stores and faults.
- resp_fault  out  1  qualified by resp_valid.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- States: IDLE, ACCESS, SPLIT, DONE. Reset forces IDLE.
- Reset forces every output to 0 except req_ready, which is 1.
- All mem_* outputs are decoded combinationally from the state and latched registers. Asserting rst_n low in mid-operation therefore deasserts mem_read and mem_write in the same instant.
- IDLE, on acceptance, latches the request. Next state:
  - DONE with fault=1 when any of these hold:
    - req_load == req_store;
    - req_size == 11;
    - req_addr + nbytes - 1 >= MEM_BYTES, where nbytes is 4, 2 or 1.
  - ACCESS when the address is aligned: word requires addr[1:0]==0; halfword requires addr[0]==0; a byte is always aligned.
  - SPLIT otherwise, with byte index idx = 0.
- ACCESS lasts exactly one cycle:
  - mem_read or mem_write = 1;
  - mem_sel = latched size;
  - mem_addr = addr[ADDR_W-1:0];
  - mem_wdata = wdata.
  - For a load, mem_rdata is captured into the result register at the end of the cycle. Next state is DONE.
- SPLIT lasts one cycle per byte, idx = 0..nbytes-1:
  - mem_sel = 10;
  - mem_addr = addr + idx;
  - mem_wdata = {24'b0, wdata[8*idx+7 : 8*idx]}.
  - For a load, mem_rdata[7:0] is captured into result byte idx.
  - At idx == nbytes-1 the next state is DONE; otherwise idx increments.
- DONE lasts exactly one cycle:
  - resp_valid = 1.
  - For a load, resp_rdata is the result register extended from bit 7 (byte) or bit 15 (halfword) according to the latched signed flag; a word is passed unchanged.
  - For a store or a fault, resp_rdata = 0.
  - Next state is IDLE.
- Latency from the acceptance edge: aligned access gives resp_valid in cycle 2; a misaligned halfword in cycle 3; a misaligned word in cycle 5; a fault in cycle 1, with no memory strobe ever asserted.
- A req_valid presented while busy is ignored and is not queued. It must be held by the requester until req_ready is high.
- mem_read and mem_write are never high in the same cycle.
- Address arithmetic within a split never wraps, because the range check guarantees addr + idx < MEM_BYTES.

Test Plan:
- Memory holds byte 9 at address 4. LW at 0x4 -> mem_read high for exactly 1 cycle with mem_sel=00 and mem_addr=4; resp_valid in cycle 2 with resp_rdata=0x00000009 and resp_fault=0.
- SW of 0xDEADBEEF at 0x5 -> 4 consecutive byte writes to addresses 5,6,7,8 with data 0xEF,0xBE,0xAD,0xDE; resp_valid in cycle 5. A following LW at 0x5 -> resp_rdata=0xDEADBEEF.
- SB of 0x80 at 0x10 -> one write with mem_sel=10. LB at 0x10 -> 0xFFFFFF80; LBU at 0x10 -> 0x00000080. LH at 0x3 over bytes 0x00,0x80 -> 2 byte reads, resp_rdata=0xFFFF8000.
- LW at 0x3E (62) -> no strobe asserted, resp_valid in cycle 1 with resp_fault=1 and resp_rdata=0. Request with req_size=11 -> fault. Request with both req_load and req_store high -> fault.
- Misaligned SW at 0x9; drive rst_n low during byte idx 2 -> mem_write drops immediately, only addresses 9 and 10 are modified, and after release req_ready=1 and busy=0.
- Second request held on req_valid during a split -> not accepted until the cycle after resp_valid; each request produces exactly one resp_valid.
